// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing the single sdram_ctrl read/write request
// interface among NUM_PORTS user masters. The winner's command is latched
// for the whole burst; data, acks and read valids are routed to it only.
module sdram_port_arb #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = 2
) (
    input  logic                      sdram_clk,
    input  logic                      sdram_rst,
    input  logic                      sdram_init_end,
    input  logic [NUM_PORTS-1:0]      port_req,
    input  logic [NUM_PORTS-1:0]      port_we,
    input  logic [NUM_PORTS*24-1:0]   port_addr,
    input  logic [NUM_PORTS*10-1:0]   port_bst_len,
    input  logic [NUM_PORTS*16-1:0]   port_wdata,
    output logic [NUM_PORTS-1:0]      port_gnt,
    output logic [NUM_PORTS-1:0]      port_wr_ack,
    output logic [NUM_PORTS-1:0]      port_rd_valid,
    output logic [15:0]               port_rd_data,
    output logic [NUM_PORTS-1:0]      port_done,
    output logic                      len_err,
    output logic                      sdram_wr_req,
    output logic [23:0]               sdram_wr_addr,
    output logic [15:0]               sdram_wr_data,
    output logic [9:0]                sdram_wr_bst_len,
    input  logic                      sdram_wr_ack,
    output logic                      sdram_rd_req,
    output logic [23:0]               sdram_rd_addr,
    output logic [9:0]                sdram_rd_bst_len,
    input  logic                      sdram_rd_ack,
    input  logic [15:0]               sdram_rd_data
);

    // state   | meaning
    // IDLE    | waiting for init done and any request
    // ARB     | pick round-robin winner, latch its command
    // WR_WAIT | write request raised, waiting for first ack
    // WR_XFER | write beats in progress, ends on first ack=0
    // RD_WAIT | read request raised, waiting for first ack
    // RD_XFER | read beats in progress, ends on first ack=0
    // DONE    | pulse port_done/len_err, advance rr_ptr
    typedef enum logic [2:0] {
        IDLE, ARB, WR_WAIT, WR_XFER, RD_WAIT, RD_XFER, DONE
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        winner;
    logic [PW-1:0]        arb_idx;
    logic [PW-1:0]        scan_idx;
    logic                 arb_found;
    logic [NUM_PORTS-1:0] gnt;
    logic                 we_r;
    logic [23:0]          addr_r;
    logic [9:0]           len_r;
    logic [9:0]           beat_cnt;
    logic                 wr_req_r;
    logic                 rd_req_r;
    logic                 cur_ack;

    logic [23:0]          addr_arr  [NUM_PORTS];
    logic [9:0]           len_arr   [NUM_PORTS];
    logic [15:0]          wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_arr[g]  = port_addr[g*24 +: 24];
        assign len_arr[g]   = port_bst_len[g*10 +: 10];
        assign wdata_arr[g] = port_wdata[g*16 +: 16];
    end

    // Ack of the burst direction currently owned by the winner.
    assign cur_ack = we_r ? sdram_wr_ack : sdram_rd_ack;

    // Round-robin scan starting at rr_ptr; first requesting port wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!arb_found && port_req[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sdram_init_end && (|port_req)) state_next = ARB;
            ARB: begin
                if (!arb_found)             state_next = IDLE;
                else if (port_we[arb_idx])  state_next = WR_WAIT;
                else                        state_next = RD_WAIT;
            end
            WR_WAIT: if (sdram_wr_ack)  state_next = WR_XFER;
            WR_XFER: if (!sdram_wr_ack) state_next = DONE;
            RD_WAIT: if (sdram_rd_ack)  state_next = RD_XFER;
            RD_XFER: if (!sdram_rd_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, request hold, beat counting and pointer update.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            rr_ptr   <= '0;
            winner   <= '0;
            gnt      <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            len_r    <= '0;
            beat_cnt <= '0;
            wr_req_r <= 1'b0;
            rd_req_r <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (arb_found) begin
                        winner   <= arb_idx;
                        gnt      <= NUM_PORTS'(1) << arb_idx;
                        we_r     <= port_we[arb_idx];
                        addr_r   <= addr_arr[arb_idx];
                        len_r    <= len_arr[arb_idx];
                        beat_cnt <= '0;
                        wr_req_r <= port_we[arb_idx];
                        rd_req_r <= ~port_we[arb_idx];
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    if (cur_ack) beat_cnt <= beat_cnt + 10'd1;
                end
                WR_XFER, RD_XFER: begin
                    if (cur_ack) begin
                        beat_cnt <= beat_cnt + 10'd1;
                    end else begin
                        wr_req_r <= 1'b0;
                        rd_req_r <= 1'b0;
                        gnt      <= '0;
                    end
                end
                DONE: begin
                    rr_ptr <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Completion pulse and length check, valid only during DONE.
    always_comb begin
        port_done = '0;
        len_err   = 1'b0;
        if (state == DONE) begin
            port_done[winner] = 1'b1;
            len_err           = (beat_cnt != len_r);
        end
    end

    assign port_gnt         = gnt;
    assign port_wr_ack      = gnt & {NUM_PORTS{sdram_wr_ack}};
    assign port_rd_valid    = gnt & {NUM_PORTS{sdram_rd_ack}};
    assign port_rd_data     = sdram_rd_data;

    assign sdram_wr_req     = wr_req_r;
    assign sdram_rd_req     = rd_req_r;
    assign sdram_wr_addr    = addr_r;
    assign sdram_rd_addr    = addr_r;
    assign sdram_wr_bst_len = len_r;
    assign sdram_rd_bst_len = len_r;
    assign sdram_wr_data    = wdata_arr[winner];

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: a behavioural sdram_ctrl responder, a scoreboard
// of expected bursts checked at each port_done, a vector table of single
// bursts and hand sequences for init gating, round-robin and reset.
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic [3:0]  port_req;
    logic [3:0]  port_we;
    logic [95:0] port_addr;
    logic [39:0] port_bst_len;
    logic [63:0] port_wdata;
    logic [3:0]  port_gnt, port_wr_ack, port_rd_valid, port_done;
    logic [15:0] port_rd_data;
    logic        len_err;
    logic        sdram_wr_req, sdram_rd_req;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [15:0] sdram_wr_data;
    logic [9:0]  sdram_wr_bst_len, sdram_rd_bst_len;
    logic        sdram_wr_ack, sdram_rd_ack;
    logic [15:0] sdram_rd_data;

    typedef struct {
        int          port;
        bit          we;
        logic [23:0] addr;
        logic [9:0]  len;
        int          beats;
        logic [15:0] rd_base;
        bit          err;
    } burst_t;

    burst_t      sb[$];
    int          issued[4];
    int          done_count[4];
    int          short_beats;
    logic [15:0] rd_base;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    sdram_port_arb #(.NUM_PORTS(4), .PW(2)) dut (
        .sdram_clk(clk), .sdram_rst(rst), .sdram_init_end(init_end),
        .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
        .port_bst_len(port_bst_len), .port_wdata(port_wdata),
        .port_gnt(port_gnt), .port_wr_ack(port_wr_ack),
        .port_rd_valid(port_rd_valid), .port_rd_data(port_rd_data),
        .port_done(port_done), .len_err(len_err),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr),
        .sdram_wr_data(sdram_wr_data), .sdram_wr_bst_len(sdram_wr_bst_len),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_req(sdram_rd_req),
        .sdram_rd_addr(sdram_rd_addr), .sdram_rd_bst_len(sdram_rd_bst_len),
        .sdram_rd_ack(sdram_rd_ack), .sdram_rd_data(sdram_rd_data)
    );

    // A port requests while it has bursts issued but not yet completed.
    always_comb begin
        port_req = '0;
        for (int p = 0; p < 4; p++) port_req[p] = (issued[p] != done_count[p]);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] onehot(input int p);
        logic [3:0] one;
        one = 4'b0001;
        return one << p;
    endfunction

    function automatic logic [15:0] wd(input int p);
        return 16'hC000 + 16'(p) * 16'h0101;
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int p = 0; p < 4; p++) s += issued[p] - done_count[p];
        return s;
    endfunction

    task automatic config_port(input int p, input bit we, input logic [23:0] addr, input logic [9:0] len);
        port_we[p]              = we;
        port_addr[p*24 +: 24]   = addr;
        port_bst_len[p*10 +: 10] = len;
    endtask

    task automatic expect_burst(input int p, input bit we, input logic [23:0] addr,
                                input logic [9:0] len, input int beats, input logic [15:0] base,
                                input bit err);
        burst_t b;
        b.port = p; b.we = we; b.addr = addr; b.len = len;
        b.beats = beats; b.rd_base = base; b.err = err;
        sb.push_back(b);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (pending() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("drain_pending", 64'(pending()), 64'd0);
        check("drain_scoreboard", 64'(sb.size()), 64'd0);
    endtask

    // Behavioural sdram_ctrl: one idle cycle after a request, then ack for
    // the latched length (or short_beats when nonzero), then ack low.
    initial begin : sdram_model
        int mst;
        int left;
        int idx;
        mst = 0; left = 0; idx = 0;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mst = 0;
                sdram_wr_ack = 1'b0;
                sdram_rd_ack = 1'b0;
            end else begin
                case (mst)
                    0: begin
                        sdram_wr_ack = 1'b0;
                        sdram_rd_ack = 1'b0;
                        if (sdram_wr_req || sdram_rd_req) begin
                            left = (short_beats != 0) ? short_beats :
                                   int'(sdram_wr_req ? sdram_wr_bst_len : sdram_rd_bst_len);
                            idx = 0;
                            mst = 1;
                        end
                    end
                    1: begin
                        if (left > 0) begin
                            if (sdram_wr_req) sdram_wr_ack = 1'b1;
                            else              sdram_rd_ack = 1'b1;
                            sdram_rd_data = rd_base + 16'(idx);
                            idx++;
                            left--;
                        end else begin
                            sdram_wr_ack = 1'b0;
                            sdram_rd_ack = 1'b0;
                            mst = 2;
                        end
                    end
                    default: if (!sdram_wr_req && !sdram_rd_req) mst = 0;
                endcase
            end
        end
    end

    // Scoreboard consumer: per-beat routing checks and per-burst completion checks.
    initial begin : monitor
        int     wr_cnt;
        int     rd_cnt;
        burst_t e;
        wr_cnt = 0; rd_cnt = 0;
        for (int p = 0; p < 4; p++) done_count[p] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_cnt = 0;
                rd_cnt = 0;
                sb.delete();
            end else begin
                if (port_wr_ack != 0) begin
                    if (sb.size() == 0) check("wr_ack_stray", 64'(port_wr_ack), 64'd0);
                    else begin
                        check("wr_ack_port", 64'(port_wr_ack), 64'(onehot(sb[0].port)));
                        check("wr_data", 64'(sdram_wr_data), 64'(wd(sb[0].port)));
                        wr_cnt++;
                    end
                end
                if (port_rd_valid != 0) begin
                    if (sb.size() == 0) check("rd_valid_stray", 64'(port_rd_valid), 64'd0);
                    else begin
                        check("rd_valid_port", 64'(port_rd_valid), 64'(onehot(sb[0].port)));
                        check("rd_data", 64'(port_rd_data), 64'(sb[0].rd_base + 16'(rd_cnt)));
                        rd_cnt++;
                    end
                end
                if (port_done != 0) begin
                    if (sb.size() == 0) check("done_stray", 64'(port_done), 64'd0);
                    else begin
                        e = sb.pop_front();
                        check("done_port", 64'(port_done), 64'(onehot(e.port)));
                        check("len_err", 64'(len_err), 64'(e.err));
                        if (e.we) begin
                            check("wr_addr", 64'(sdram_wr_addr), 64'(e.addr));
                            check("wr_len", 64'(sdram_wr_bst_len), 64'(e.len));
                            check("wr_beats", 64'(wr_cnt), 64'(e.beats));
                            check("rd_beats_in_write", 64'(rd_cnt), 64'd0);
                        end else begin
                            check("rd_addr", 64'(sdram_rd_addr), 64'(e.addr));
                            check("rd_len", 64'(sdram_rd_bst_len), 64'(e.len));
                            check("rd_beats", 64'(rd_cnt), 64'(e.beats));
                            check("wr_beats_in_read", 64'(wr_cnt), 64'd0);
                        end
                        done_count[e.port]++;
                    end
                    wr_cnt = 0;
                    rd_cnt = 0;
                end else if (len_err) begin
                    check("len_err_stray", 64'(len_err), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        burst_t vecs[7];
        int     n;

        vecs[0] = '{port:0, we:1, addr:24'h012345, len:10'd8,   beats:8,   rd_base:16'h0000, err:0};
        vecs[1] = '{port:2, we:0, addr:24'hABCDE0, len:10'd4,   beats:4,   rd_base:16'h00A0, err:0};
        vecs[2] = '{port:1, we:1, addr:24'h100200, len:10'd16,  beats:10,  rd_base:16'h0000, err:1};
        vecs[3] = '{port:3, we:0, addr:24'h3FFFFF, len:10'd1,   beats:1,   rd_base:16'h5550, err:0};
        vecs[4] = '{port:0, we:0, addr:24'h000010, len:10'd6,   beats:7,   rd_base:16'h1230, err:1};
        vecs[5] = '{port:2, we:1, addr:24'h222222, len:10'd2,   beats:1,   rd_base:16'h0000, err:1};
        vecs[6] = '{port:3, we:1, addr:24'hFFFFFF, len:10'd512, beats:512, rd_base:16'h0000, err:0};

        rst = 1'b1;
        init_end = 1'b0;
        short_beats = 0;
        rd_base = '0;
        port_we = '0;
        port_addr = '0;
        port_bst_len = '0;
        for (int p = 0; p < 4; p++) begin
            issued[p] = 0;
            port_wdata[p*16 +: 16] = wd(p);
        end

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(port_gnt), 64'd0);
        check("rst_done", 64'(port_done), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_reqs", 64'({sdram_wr_req, sdram_rd_req}), 64'd0);
        check("rst_addrs", 64'({sdram_wr_addr, sdram_rd_addr}), 64'd0);
        check("rst_lens", 64'({sdram_wr_bst_len, sdram_rd_bst_len}), 64'd0);
        #1 rst = 1'b0;

        // All four request with init_end low; nothing may be granted.
        // Once init_end rises the grant order is 0,1,2,3 then 0 again.
        for (int p = 0; p < 4; p++) config_port(p, 1'b1, (24'(p) << 20) | 24'h000040, 10'(3 + p));
        expect_burst(0, 1'b1, 24'h000040, 10'd3, 3, 16'h0, 1'b0);
        expect_burst(1, 1'b1, 24'h100040, 10'd4, 4, 16'h0, 1'b0);
        expect_burst(2, 1'b1, 24'h200040, 10'd5, 5, 16'h0, 1'b0);
        expect_burst(3, 1'b1, 24'h300040, 10'd6, 6, 16'h0, 1'b0);
        expect_burst(0, 1'b1, 24'h000040, 10'd3, 3, 16'h0, 1'b0);
        issued[0] = 2; issued[1] = 1; issued[2] = 1; issued[3] = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("no_gnt_before_init", 64'({port_gnt, sdram_wr_req, sdram_rd_req}), 64'd0);
        end
        #1 init_end = 1'b1;
        drain(500);

        // Vector table: single-requester bursts.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            #1;
            config_port(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].len);
            short_beats = vecs[v].beats;
            rd_base = vecs[v].rd_base;
            sb.push_back(vecs[v]);
            issued[vecs[v].port]++;
            drain(1000);
        end

        // init_end falls mid-burst: burst completes, then no new grant until it returns.
        @(negedge clk);
        #1;
        config_port(1, 1'b0, 24'h0A0B0C, 10'd6);
        short_beats = 6;
        rd_base = 16'h7700;
        expect_burst(1, 1'b0, 24'h0A0B0C, 10'd6, 6, 16'h7700, 1'b0);
        issued[1]++;
        n = 0;
        while (!sdram_rd_req && n < 100) begin @(negedge clk); n++; end
        check("rd_req_raised", 64'(sdram_rd_req), 64'd1);
        #1 init_end = 1'b0;
        drain(200);
        config_port(0, 1'b1, 24'h004400, 10'd2);
        short_beats = 2;
        expect_burst(0, 1'b1, 24'h004400, 10'd2, 2, 16'h0, 1'b0);
        issued[0]++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("no_gnt_init_low", 64'({port_gnt, sdram_wr_req, sdram_rd_req}), 64'd0);
        end
        #1 init_end = 1'b1;
        drain(200);

        // Reset during RD_XFER on port 2, then ports 0 and 3 together:
        // pointer is back at 0 so port 0 wins first.
        @(negedge clk);
        #1;
        config_port(2, 1'b0, 24'h0C0000, 10'd20);
        short_beats = 20;
        rd_base = 16'h9000;
        expect_burst(2, 1'b0, 24'h0C0000, 10'd20, 20, 16'h9000, 1'b0);
        issued[2]++;
        n = 0;
        while (!port_rd_valid[2] && n < 100) begin @(negedge clk); n++; end
        check("rd_valid_seen", 64'(port_rd_valid[2]), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rd_req", 64'(sdram_rd_req), 64'd0);
        check("async_rst_gnt", 64'(port_gnt), 64'd0);
        issued[2] = done_count[2];
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        config_port(0, 1'b1, 24'h000AAA, 10'd3);
        config_port(3, 1'b1, 24'h333AAA, 10'd3);
        short_beats = 3;
        expect_burst(0, 1'b1, 24'h000AAA, 10'd3, 3, 16'h0, 1'b0);
        expect_burst(3, 1'b1, 24'h333AAA, 10'd3, 3, 16'h0, 1'b0);
        issued[0]++;
        issued[3]++;
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
